// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide unit with its own sequencer for the E stage.
//   Accepts one mult/multu/div/divu/mthi/mtlo operation per start pulse.
//   It holds HI/LO and models a fixed multi-cycle latency with a registered busy.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             operation-valid pulse, sampled on rising clk
//   md_op[3:0]        0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd,8 msub
//   rs_data, rt_data  forwarded operands
//   busy              high while an operation is in flight
//   hi, lo            architectural HI/LO registers
// Optional feature: define MD_MADD_EN to enable madd/msub (codes 7/8).
//   When MD_MADD_EN is not defined, codes 7/8 are no-ops.
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;

    // Latency parameters must fit the 4-bit down-counter and be non-zero.
    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
        $error("md_unit_ctrl: MULT_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("md_unit_ctrl: DIV_CYCLES must be in 1..15");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_W-1:0]     pend_res;
    logic                    pend_wr;

    logic                    accept_c;
    logic [CNT_W-1:0]        cyc_c;
    logic [2*DATA_W-1:0]     res_c;
    logic                    wr_c;
    logic [2*DATA_W-1:0]     prod_s_c;
    logic [2*DATA_W-1:0]     prod_u_c;
    logic [DATA_W-1:0]       quo_s_c;
    logic [DATA_W-1:0]       rem_s_c;
    logic [DATA_W-1:0]       quo_u_c;
    logic [DATA_W-1:0]       rem_u_c;
    logic                    div_ovf_c;
    logic                    div_zero_c;

    // Operand decode and result datapath for the operation being accepted.
    always_comb begin
        accept_c   = 1'b0;
        cyc_c      = CNT_W'(MULT_CYCLES);
        res_c      = '0;
        wr_c       = 1'b0;
        // Both products are exact in their low 64 bits after sign/zero extension.
        prod_s_c   = {{DATA_W{rs_data[DATA_W-1]}}, rs_data} * {{DATA_W{rt_data[DATA_W-1]}}, rt_data};
        prod_u_c   = {{DATA_W{1'b0}}, rs_data} * {{DATA_W{1'b0}}, rt_data};
        div_zero_c = (rt_data == '0);
        // 0x80000000 / -1 overflows; architected result is lo=0x80000000, hi=0.
        div_ovf_c  = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
        quo_s_c    = '0;
        rem_s_c    = '0;
        quo_u_c    = '0;
        rem_u_c    = '0;
        if (!div_zero_c) begin
            if (div_ovf_c) begin
                quo_s_c = 32'h8000_0000;
                rem_s_c = '0;
            end else begin
                quo_s_c = DATA_W'($signed(rs_data) / $signed(rt_data));
                rem_s_c = DATA_W'($signed(rs_data) % $signed(rt_data));
            end
            quo_u_c = rs_data / rt_data;
            rem_u_c = rs_data % rt_data;
        end

        case (md_op)
            OP_MULT: begin
                accept_c = 1'b1;
                res_c    = prod_s_c;
                wr_c     = 1'b1;
            end
            OP_MULTU: begin
                accept_c = 1'b1;
                res_c    = prod_u_c;
                wr_c     = 1'b1;
            end
            OP_DIV: begin
                accept_c = 1'b1;
                cyc_c    = CNT_W'(DIV_CYCLES);
                res_c    = {rem_s_c, quo_s_c};
                wr_c     = !div_zero_c;
            end
            OP_DIVU: begin
                accept_c = 1'b1;
                cyc_c    = CNT_W'(DIV_CYCLES);
                res_c    = {rem_u_c, quo_u_c};
                wr_c     = !div_zero_c;
            end
`ifdef MD_MADD_EN
            // Accumulate against HI/LO as committed at accept time.
            OP_MADD: begin
                accept_c = 1'b1;
                res_c    = {hi, lo} + prod_s_c;
                wr_c     = 1'b1;
            end
            OP_MSUB: begin
                accept_c = 1'b1;
                res_c    = {hi, lo} - prod_s_c;
                wr_c     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer: IDLE accepts ops, RUN counts down the latency and commits HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            pend_res <= '0;
            pend_wr  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (accept_c) begin
                            state    <= ST_RUN;
                            cnt      <= cyc_c;
                            busy     <= 1'b1;
                            pend_res <= res_c;
                            pend_wr  <= wr_c;
                        end else if (md_op == OP_MTHI) begin
                            hi <= rs_data;
                        end else if (md_op == OP_MTLO) begin
                            lo <= rs_data;
                        end
                    end
                end
                ST_RUN: begin
                    // start is ignored here; the hazard unit never issues one.
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        if (pend_wr) begin
                            hi <= pend_res[2*DATA_W-1:DATA_W];
                            lo <= pend_res[DATA_W-1:0];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl with default latencies (mult 5, div 10).
module tb_md_unit_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;

    md_unit_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle start pulse; returns one cycle after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        md_op   = op;
        rs_data = rs;
        rt_data = rt;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        md_op   = 4'd0;
    endtask

    // Expect busy high for n more cycles, then low.
    task automatic expect_busy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(busy), 32'd1);
            tick();
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        md_op   = 4'd0;
        rs_data = '0;
        rt_data = '0;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1. mult 3 * -2
        issue(4'd1, 32'd3, 32'hFFFF_FFFE);
        expect_busy("mult_busy", 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // 2. multu 0xFFFFFFFF * 2
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        expect_busy("multu_busy", 5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // 3. div -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        expect_busy("div_busy", 10);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        // Signed divide overflow case
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_busy("divovf_busy", 10);
        chk("divovf_hi", hi, 32'h0);
        chk("divovf_lo", lo, 32'h8000_0000);

        // divu 100 / 7
        issue(4'd4, 32'd100, 32'd7);
        expect_busy("divu_busy", 10);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        // 4. mthi/mtlo then divide by zero leaves HI/LO unchanged
        issue(4'd5, 32'h11, 32'h0);
        chk("mthi11_busy", 32'(busy), 32'd0);
        chk("mthi11_hi", hi, 32'h11);
        issue(4'd6, 32'h22, 32'h0);
        chk("mtlo22_busy", 32'(busy), 32'd0);
        chk("mtlo22_lo", lo, 32'h22);
        issue(4'd4, 32'd5, 32'd0);
        expect_busy("div0_busy", 10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        // md_op 0 and undefined code with start: no effect
        issue(4'd0, 32'hDEAD_BEEF, 32'd1);
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_hi", hi, 32'h11);
        issue(4'd12, 32'hDEAD_BEEF, 32'd1);
        chk("undef_busy", 32'(busy), 32'd0);
        chk("undef_lo", lo, 32'h22);

        // 5. mthi in IDLE, then mult with a second start dropped mid-RUN
        issue(4'd5, 32'hABCD_0000, 32'h0);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_hi", hi, 32'hABCD_0000);
        issue(4'd1, 32'd4, 32'd5);
        chk("midrun_busy1", 32'(busy), 32'd1);
        tick();
        chk("midrun_busy2", 32'(busy), 32'd1);
        md_op   = 4'd1;
        rs_data = 32'd7;
        rt_data = 32'd9;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        md_op   = 4'd0;
        expect_busy("midrun_busy", 3);
        chk("midrun_hi", hi, 32'h0);
        chk("midrun_lo", lo, 32'd20);
        tick();
        chk("midrun_idle", 32'(busy), 32'd0);

        // 6. reset at busy cycle 4 of a div aborts without commit
        issue(4'd5, 32'h5555_5555, 32'h0);
        issue(4'd3, 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_nocommit_busy", 32'(busy), 32'd0);
        chk("abort_nocommit_hi", hi, 32'h0);
        chk("abort_nocommit_lo", lo, 32'h0);

`ifdef MD_MADD_EN
        issue(4'd6, 32'd1, 32'h0);
        issue(4'd7, 32'd2, 32'd3);
        expect_busy("madd_busy", 5);
        chk("madd_hi", hi, 32'h0);
        chk("madd_lo", lo, 32'd7);
        issue(4'd8, 32'd2, 32'd5);
        expect_busy("msub_busy", 5);
        chk("msub_hi", hi, 32'hFFFF_FFFF);
        chk("msub_lo", lo, 32'hFFFF_FFFD);
`else
        issue(4'd6, 32'd1, 32'h0);
        issue(4'd7, 32'd2, 32'd3);
        chk("madd_off_busy", 32'(busy), 32'd0);
        chk("madd_off_lo", lo, 32'd1);
        issue(4'd8, 32'd2, 32'd5);
        chk("msub_off_busy", 32'(busy), 32'd0);
        chk("msub_off_hi", hi, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
